// File: rtl/mealy_table_fsm.sv
// mealy_table_fsm
// Runtime-programmable Mealy automaton. The transition/output table lives in
// registers and is written through a configuration port, so one netlist covers
// any automaton with 2**ST_W states, IN_W-bit input symbols and OUT_W-bit
// output symbols. After reset every entry is a self-loop that holds the output.
//
// Ports
//   clk           : clock, rising edge
//   reset         : synchronous, active-high; overrides cfg_we and in_valid
//   in_valid      : step the automaton this cycle
//   a             : input symbol
//   b             : registered Mealy output
//   b_strobe      : one-cycle pulse, b was written by the last step
//   state         : current state
//   state_changed : one-cycle pulse, last step moved to a different state
//   cfg_we        : table write enable
//   cfg_addr      : table index {state, symbol}
//   cfg_wdata     : entry {out_en, out_val, next_state}
//   cfg_rdata     : registered readback of table[cfg_addr]
module mealy_table_fsm #(
    parameter int unsigned ST_W        = 2,
    parameter int unsigned IN_W        = 2,
    parameter int unsigned OUT_W       = 2,
    parameter int unsigned RESET_STATE = 0,
    parameter int unsigned RESET_OUT   = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [IN_W-1:0]         a,
    output logic [OUT_W-1:0]        b,
    output logic                    b_strobe,
    output logic [ST_W-1:0]         state,
    output logic                    state_changed,
    input  logic                    cfg_we,
    input  logic [ST_W+IN_W-1:0]    cfg_addr,
    input  logic [ST_W+OUT_W:0]     cfg_wdata,
    output logic [ST_W+OUT_W:0]     cfg_rdata
);

    localparam int unsigned AW    = ST_W + IN_W;
    localparam int unsigned EW    = ST_W + OUT_W + 1;
    localparam int unsigned DEPTH = 2 ** AW;

    logic [EW-1:0]    table_r [DEPTH];
    logic [EW-1:0]    entry_s;
    logic             entry_en_s;
    logic [OUT_W-1:0] entry_val_s;
    logic [ST_W-1:0]  entry_next_s;

    logic [ST_W-1:0]  state_r;
    logic [OUT_W-1:0] b_r;
    logic             b_strobe_r;
    logic             state_changed_r;
    logic [EW-1:0]    cfg_rdata_r;

    // Look up the entry selected by the current state and the incoming symbol.
    // The table register still holds its pre-write value here, which gives
    // read-before-write behaviour when a step and a write hit the same edge.
    always_comb begin
        entry_s      = table_r[{state_r, a}];
        entry_next_s = entry_s[ST_W-1:0];
        entry_val_s  = entry_s[ST_W +: OUT_W];
        entry_en_s   = entry_s[EW-1];
    end

    // Table storage: reset loads self-loops (next_state = state field of the
    // index, out_en = 0), otherwise accept configuration writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                table_r[i] <= {1'b0, {OUT_W{1'b0}}, ST_W'(i >> IN_W)};
            end
        end else if (cfg_we) begin
            table_r[cfg_addr] <= cfg_wdata;
        end
    end

    // Automaton step: advance state, optionally update the output, and raise
    // the one-cycle pulses; idle cycles hold state/output and clear pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_W'(RESET_STATE);
            b_r             <= OUT_W'(RESET_OUT);
            b_strobe_r      <= 1'b0;
            state_changed_r <= 1'b0;
        end else if (in_valid) begin
            state_r         <= entry_next_s;
            state_changed_r <= (entry_next_s != state_r);
            b_strobe_r      <= entry_en_s;
            if (entry_en_s) begin
                b_r <= entry_val_s;
            end
        end else begin
            b_strobe_r      <= 1'b0;
            state_changed_r <= 1'b0;
        end
    end

    // Registered readback of the addressed entry (old value on a same-edge write).
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_rdata_r <= {EW{1'b0}};
        end else begin
            cfg_rdata_r <= table_r[cfg_addr];
        end
    end

    assign state         = state_r;
    assign b             = b_r;
    assign b_strobe      = b_strobe_r;
    assign state_changed = state_changed_r;
    assign cfg_rdata     = cfg_rdata_r;

endmodule

// File: tb/tb_mealy_table_fsm.sv
module tb_mealy_table_fsm;

    logic clk = 1'b0;
    logic reset;

    // default-parameter instance
    logic       v0, bs0, sc0, we0;
    logic [1:0] a0, b0, st0;
    logic [3:0] ad0;
    logic [4:0] wd0, rd0;

    // sweep instance: ST_W=3, IN_W=3, OUT_W=4, RESET_STATE=5, RESET_OUT=9
    logic       v1, bs1, sc1, we1;
    logic [2:0] a1, st1;
    logic [3:0] b1;
    logic [5:0] ad1;
    logic [7:0] wd1, rd1;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    mealy_table_fsm u0 (
        .clk(clk), .reset(reset), .in_valid(v0), .a(a0), .b(b0), .b_strobe(bs0),
        .state(st0), .state_changed(sc0), .cfg_we(we0), .cfg_addr(ad0),
        .cfg_wdata(wd0), .cfg_rdata(rd0)
    );

    mealy_table_fsm #(.ST_W(3), .IN_W(3), .OUT_W(4), .RESET_STATE(5), .RESET_OUT(9)) u1 (
        .clk(clk), .reset(reset), .in_valid(v1), .a(a1), .b(b1), .b_strobe(bs1),
        .state(st1), .state_changed(sc1), .cfg_we(we1), .cfg_addr(ad1),
        .cfg_wdata(wd1), .cfg_rdata(rd1)
    );

    // ---------------- behavioural model of u0 (integer table) ----------------
    int m_next [16];
    int m_en   [16];
    int m_val  [16];
    int m_state, m_b, m_strobe, m_chg, m_rdata;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                m_next[i] <= i / 4;
                m_en[i]   <= 0;
                m_val[i]  <= 0;
            end
            m_state  <= 0;
            m_b      <= 0;
            m_strobe <= 0;
            m_chg    <= 0;
            m_rdata  <= 0;
        end else begin
            if (v0) begin
                m_state  <= m_next[m_state * 4 + int'(a0)];
                m_chg    <= (m_next[m_state * 4 + int'(a0)] != m_state) ? 1 : 0;
                m_strobe <= m_en[m_state * 4 + int'(a0)];
                if (m_en[m_state * 4 + int'(a0)] == 1)
                    m_b <= m_val[m_state * 4 + int'(a0)];
            end else begin
                m_strobe <= 0;
                m_chg    <= 0;
            end
            if (we0) begin
                m_en[ad0]   <= (int'(wd0) / 16) % 2;
                m_val[ad0]  <= (int'(wd0) / 4) % 4;
                m_next[ad0] <= int'(wd0) % 4;
            end
            m_rdata <= m_en[ad0] * 16 + m_val[ad0] * 4 + m_next[ad0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison of u0 against the model
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("mon_state",   32'(st0), 32'(m_state));
                chk("mon_b",       32'(b0),  32'(m_b));
                chk("mon_strobe",  32'(bs0), 32'(m_strobe));
                chk("mon_changed", 32'(sc0), 32'(m_chg));
                chk("mon_rdata",   32'(rd0), 32'(m_rdata));
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input logic [1:0] av,
                       input logic we, input logic [3:0] ad, input logic [4:0] wd);
        @(negedge clk); #1;
        reset = r; v0 = v; a0 = av; we0 = we; ad0 = ad; wd0 = wd;
        v1 = 1'b0; we1 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cyc1(input logic v, input logic [2:0] av, input logic we,
                        input logic [5:0] ad, input logic [7:0] wd);
        @(negedge clk); #1;
        reset = 1'b0; v1 = v; a1 = av; we1 = we; ad1 = ad; wd1 = wd;
        v0 = 1'b0; we0 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic exp0(input string nm, input int s, input int bb, input int bs, input int sc);
        chk({nm, "_state"},   32'(st0), 32'(s));
        chk({nm, "_b"},       32'(b0),  32'(bb));
        chk({nm, "_strobe"},  32'(bs0), 32'(bs));
        chk({nm, "_changed"}, 32'(sc0), 32'(sc));
    endtask

    logic [3:0] prog_ad [10] = '{4'd2, 4'd3, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13, 4'd15, 4'd0, 4'd1};
    logic [4:0] prog_wd [10] = '{5'b11001, 5'b11110, 5'b10000, 5'b10011, 5'b11000,
                                 5'b11101, 5'b10111, 5'b10101, 5'b10100, 5'b10100};
    int seq_a  [5] = '{3, 1, 1, 3, 3};
    int seq_st [5] = '{2, 3, 3, 1, 0};
    int seq_b  [5] = '{3, 0, 1, 1, 0};
    int seq_sc [5] = '{1, 1, 0, 1, 1};

    logic [5:0] ring_ad [4] = '{6'd47, 6'd55, 6'd63, 6'd7};
    logic [7:0] ring_wd [4] = '{8'b10110110, 8'b10111111, 8'b11000000, 8'b10001001};
    int ring_st [4] = '{6, 7, 0, 1};
    int ring_b  [4] = '{6, 7, 8, 1};

    initial begin
        reset = 1'b1; v0 = 1'b0; a0 = 2'd0; we0 = 1'b0; ad0 = 4'd0; wd0 = 5'd0;
        v1 = 1'b0; a1 = 3'd0; we1 = 1'b0; ad1 = 6'd0; wd1 = 8'd0;

        // reset defaults
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 5'd0);
        mon_en = 1'b1;
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 4'd0, 5'd0);
        exp0("rst", 0, 0, 0, 0);
        chk("rst_rdata", 32'(rd0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 2'(i), 1'b0, 4'd6, 5'd0);
            exp0("rstdef", 0, 0, 0, 0);
            chk("rstdef_rdata6", 32'(rd0), 32'd1);
        end

        // program lab automaton
        for (int i = 0; i < 10; i++)
            cyc(1'b0, 1'b0, 2'd0, 1'b1, prog_ad[i], prog_wd[i]);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 2'(seq_a[i]), 1'b0, 4'd3, 5'd0);
            exp0("lab", seq_st[i], seq_b[i], 1, seq_sc[i]);
        end
        chk("lab_rdata3", 32'(rd0), 32'b11110);

        // hold semantics: reach state 1 with b=2, then unprogrammed symbol
        cyc(1'b0, 1'b1, 2'd2, 1'b0, 4'd0, 5'd0);
        exp0("to1", 1, 2, 1, 1);
        cyc(1'b0, 1'b1, 2'd1, 1'b0, 4'd0, 5'd0);
        exp0("hold", 1, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 2'd3, 1'b0, 4'd0, 5'd0);
            exp0("idle", 1, 2, 0, 0);
        end

        // write/step collision on entry {0,2}
        cyc(1'b0, 1'b1, 2'd3, 1'b0, 4'd0, 5'd0);
        exp0("back0", 0, 0, 1, 1);
        cyc(1'b0, 1'b1, 2'd2, 1'b1, 4'd2, 5'b10111);
        exp0("coll", 1, 2, 1, 1);
        chk("coll_rdata_old", 32'(rd0), 32'b11001);
        cyc(1'b0, 1'b1, 2'd3, 1'b0, 4'd2, 5'd0);
        exp0("coll_back0", 0, 0, 1, 1);
        chk("coll_rdata_new", 32'(rd0), 32'b10111);
        cyc(1'b0, 1'b1, 2'd2, 1'b0, 4'd2, 5'd0);
        exp0("coll_new", 3, 1, 1, 1);

        // reset in the middle of a step burst, with a write pending
        cyc(1'b0, 1'b1, 2'd3, 1'b0, 4'd0, 5'd0);
        exp0("burst", 1, 1, 1, 1);
        cyc(1'b1, 1'b1, 2'd3, 1'b1, 4'd2, 5'b11111);
        exp0("midrst", 0, 0, 0, 0);
        chk("midrst_rdata", 32'(rd0), 32'd0);
        chk("sweep_rst_state", 32'(st1), 32'd5);
        chk("sweep_rst_b", 32'(b1), 32'd9);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 2'(3 - i), 1'b0, 4'd2, 5'd0);
            exp0("postrst", 0, 0, 0, 0);
            chk("postrst_rdata2", 32'(rd0), 32'd0);
        end

        // parameter sweep instance: ring 5->6->7->0->1 on symbol 7
        for (int i = 0; i < 4; i++)
            cyc1(1'b0, 3'd0, 1'b1, ring_ad[i], ring_wd[i]);
        cyc1(1'b0, 3'd0, 1'b0, 6'd63, 8'd0);
        chk("sweep_rdata77", 32'(rd1), 32'hC0);
        chk("sweep_idle_state", 32'(st1), 32'd5);
        for (int i = 0; i < 4; i++) begin
            cyc1(1'b1, 3'd7, 1'b0, 6'd63, 8'd0);
            chk("sweep_state", 32'(st1), 32'(ring_st[i]));
            chk("sweep_b", 32'(b1), 32'(ring_b[i]));
            chk("sweep_strobe", 32'(bs1), 32'd1);
            chk("sweep_changed", 32'(sc1), 32'd1);
        end
        cyc1(1'b0, 3'd0, 1'b0, 6'd0, 8'd0);
        chk("sweep_end_strobe", 32'(bs1), 32'd0);
        chk("sweep_end_state", 32'(st1), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mealy_table_fsm.md
# mealy_table_fsm

Runtime-programmable, parametrised Mealy automaton for the synchronous-automata lab set. State count, input alphabet and output alphabet are set by parameters. The transition/output table is held in registers and loaded through a configuration port, so one netlist implements any automaton of the given size. Unspecified transitions default to "stay in state, hold output". The block sits between a stimulus source and downstream logic and replaces per-exercise hand-coded FSMs.

## Interface
- `ST_W`, default 2: state code width; number of states is 2**ST_W.
- `IN_W`, default 2: input symbol width.
- `OUT_W`, default 2: output symbol width.
- `RESET_STATE`, default 0: state loaded on reset.
- `RESET_OUT`, default 0: output value loaded on reset.
- `clk` input 1: clock, all logic on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_valid` input 1: input symbol present; the automaton steps only on cycles with `in_valid`=1.
- `a` input IN_W: input symbol.
- `b` output OUT_W: registered Mealy output.
- `b_strobe` output 1: one-cycle pulse, `b` was written by the last step.
- `state` output ST_W: current state.
- `state_changed` output 1: one-cycle pulse, last step moved to a different state.
- `cfg_we` input 1: table write enable.
- `cfg_addr` input ST_W+IN_W: table index {state, symbol}; state in the MSBs.
- `cfg_wdata` input ST_W+OUT_W+1: entry {out_en, out_val, next_state}.
- `cfg_rdata` output ST_W+OUT_W+1: registered readback of the entry at `cfg_addr`.

## Operation
- Table: 2**(ST_W+IN_W) entries, each entry is {out_en[1], out_val[OUT_W], next_state[ST_W]}.
- Reset, including reset asserted mid-operation:
  - `state`=RESET_STATE, `b`=RESET_OUT, `b_strobe`=0, `state_changed`=0, `cfg_rdata`=0.
  - Every entry i is set to {out_en=0, out_val=0, next_state=i[ST_W+IN_W-1:IN_W]}, i.e. self-loop with output hold.
  - Reset overrides `cfg_we` and `in_valid` on the same edge.
- Step, on a cycle with `in_valid`=1 and `reset`=0:
  - Read entry E = table[{state, a}].
  - `state` <= E.next_state.
  - If E.out_en=1: `b` <= E.out_val and `b_strobe` <= 1. Otherwise `b` is unchanged and `b_strobe` <= 0.
  - `state_changed` <= (E.next_state != state).
- Cycle with `in_valid`=0: `state` and `b` hold; `b_strobe` and `state_changed` are 0.
- Configuration write, `cfg_we`=1: table[cfg_addr] <= cfg_wdata. Writes are accepted in any state and at any time.
- Write and step on the same edge, including the same entry: the step uses the entry value from before the write (read-before-write). The new value takes effect from the next step.
- Readback: `cfg_rdata` <= table[cfg_addr] every cycle. A write and a read of the same address on the same edge returns the old value.
- There are no illegal codes. All 2**ST_W states are reachable and need no default recovery. Symbol 0 is an ordinary symbol.
- All arithmetic is unsigned. Indexes are a straight concatenation with no wrap logic.

## Timing
- Step latency: input sampled at edge N, and `state`/`b`/pulses are valid after edge N. The output is registered, not combinational from `a`.
- Throughput: one step per cycle. Back-to-back `in_valid` is allowed.
- Config write latency: 1 edge until visible to a step.
- Readback latency: 1 edge (address at N, data after N).
- `b_strobe`/`state_changed` are high for exactly one cycle per qualifying step.

## Test plan
- Reset defaults:
  - Stimulus: assert reset 2 cycles, then step a=0,1,2,3 with no config.
  - Required: `state` stays 0, `b` stays RESET_OUT, `b_strobe`=0, `state_changed`=0 throughout.
  - Readback: addr 6 reads {0,0,1}.
- Program lab automaton (defaults):
  - Program: {0,2} -> next 1 out 2; {0,3} -> next 2 out 3; {1,3} -> next 0 out 0; {2,1} -> next 3 out 0; {2,2} -> next 0 out 2; {2,3} -> next 1 out 3; {3,1} -> next 3 out 1; {3,3} -> next 1 out 1; {0,0},{0,1} -> next 0 out 1; all with out_en=1.
  - Sequence a=3,1,1,3,3: required state 2,3,3,1,0 and b 3,0,1,1,0.
- Hold semantics:
  - Stimulus: in state 1 with b=2, step a=1 (unprogrammed).
  - Required: state 1, b=2, `b_strobe`=0, `state_changed`=0.
  - Then drop `in_valid` 3 cycles: nothing changes.
- Write/step collision:
  - Stimulus: in state 0, same edge: step a=2 and write {0,2} <- next 3 out 1.
  - Required: old entry applied (state 1, b=2). After returning to 0, next a=2 gives state 3, b=1.
- Reset mid-operation:
  - Stimulus: after programming, assert reset during a burst of `in_valid` steps.
  - Required: next cycle state=RESET_STATE, b=RESET_OUT. The table reverts to self-loops (subsequent steps do not move state).
- Parameter sweep:
  - Configuration: ST_W=3, IN_W=3, OUT_W=4, RESET_STATE=5, RESET_OUT=9.
  - Program a ring 5->6->7->0 on symbol 7 with out=state+1.
  - Required: 4 steps give states 6,7,0,1 (entry {0,7} programmed ->1, out 1), b 6,7,8,1. Readback of entry {7,7} returns the programmed value 1 cycle after address.
